// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode scanner: shadow-registered hex word, one nibble per REFRESH_DIV-cycle slot.
// Outputs decode registered state only; load is visible 1 cycle later; no backpressure; `LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [3:0]                    hex_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic                    en_q;
  logic                    tick;
  logic                    lit;

  always_comb begin
    tick     = enable && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end
    if (load) begin
      shadow_d = value;
      sdp_d    = dp_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
    end
  end

  // Enable is registered so the anode drive never sees a combinational input path.
  always_ff @(posedge clk) begin
    en_q <= enable;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (shadow_q[4*k +: 4] != 4'h0) begin
        msd = IDX_W'(k);
      end
    end
  end

  assign lit = (idx_q <= msd);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    an = '1;
    if (en_q && lit) begin
      an[idx_q] = 1'b0;
    end
  end

  assign hex_out   = shadow_q[{idx_q, 2'b00} +: 4];
  assign dp_n      = ~(en_q && lit && sdp_q[idx_q]);
  assign digit_idx = idx_q;

endmodule
